// File: rtl/req_ack_pkg.sv
// Shared types and constants for the req/ack pattern generator.
// Holds the FSM state encoding and the LFSR step used for gap jitter.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    GAP
  } ra_state_e;

  // x^8+x^6+x^5+x^4+1 as a mask over bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] seed_fix(
    input logic [7:0] s
  );
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  function automatic int cnt_width(
    input int sd,
    input int gmax
  );
    int m;
    m = (sd > gmax) ? sd : gmax;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ra_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when adv is high.
// A zero seed would lock up, so it is replaced by 8'h01.
module ra_lfsr8
  import req_ack_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= seed_fix(seed);
    end else if (adv) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/req_ack_generator.sv
// Free-running req ##1 ack pattern source with a programmable
// idle gap and optional LFSR jitter on that gap.
module req_ack_generator
  import req_ack_pkg::*;
#(
  parameter int         START_DELAY = 1,
  parameter int         GAP_CYCLES  = 2,
  parameter bit         JITTER_EN   = 1'b0,
  parameter logic [3:0] JITTER_MASK = 4'h3,
  parameter logic [7:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic req,
  output logic ack
);

  localparam int CW =
    cnt_width(START_DELAY, GAP_CYCLES + int'(JITTER_MASK));
  localparam logic [CW-1:0] SD_INIT = CW'(START_DELAY);
  localparam logic [CW-1:0] GAP_BASE = CW'(GAP_CYCLES);

  ra_state_e     state;
  logic [CW-1:0] cnt;
  logic [7:0]    lfsr_val;
  logic [7:0]    jit;
  logic [CW-1:0] gap_load;

  generate
    if (JITTER_EN) begin : g_jit
      ra_lfsr8 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .adv     (state == ACK),
        .seed    (LFSR_SEED),
        .value   (lfsr_val)
      );
    end else begin : g_nojit
      assign lfsr_val = 8'h00;
    end
  endgenerate

  assign jit      = lfsr_val & {4'h0, JITTER_MASK};
  assign gap_load = GAP_BASE + CW'(jit);

  // req/ack are registered alongside the state they decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= SD_INIT;
      req   <= 1'b0;
      ack   <= 1'b0;
    end else begin
      req <= 1'b0;
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cnt == '0) begin
            state <= REQ;
            req   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        REQ: begin
          state <= ACK;
          ack   <= 1'b1;
        end
        ACK: begin
          cnt <= gap_load;
          if (gap_load != '0) begin
            state <= GAP;
          end else begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        GAP: begin
          if (cnt <= CW'(1)) begin
            state <= REQ;
            req   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_generator.sv
// Scoreboard bench: three generator configurations checked
// cycle by cycle against an expected req/ack waveform queue.
module tb_req_ack_generator;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] req_w;
  logic [2:0] ack_w;
  logic [2:0] prv;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  int         tests = 0;
  int         fails = 0;
  int         hits  = 0;

  always #5 clk = ~clk;

  req_ack_generator u_def (
    .clk     (clk),
    .reset_n (rst_n[0]),
    .req     (req_w[0]),
    .ack     (ack_w[0])
  );

  req_ack_generator #(
    .START_DELAY (0),
    .GAP_CYCLES  (0)
  ) u_b2b (
    .clk     (clk),
    .reset_n (rst_n[1]),
    .req     (req_w[1]),
    .ack     (ack_w[1])
  );

  req_ack_generator #(
    .JITTER_EN (1'b1),
    .LFSR_SEED (8'hA5)
  ) u_jit (
    .clk     (clk),
    .reset_n (rst_n[2]),
    .req     (req_w[2]),
    .ack     (ack_w[2])
  );

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  task automatic push(input int idx, input logic [1:0] v);
    case (idx)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // expected waveform after each edge following reset release
  task automatic fill(
    input int idx,
    input int sd,
    input int gap,
    input bit jit,
    input int n
  );
    logic [7:0] l;
    int len;
    int g;
    l = 8'hA5;
    len = 0;
    case (idx)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
    repeat (sd) begin
      push(idx, 2'b00);
      len++;
    end
    while (len < n) begin
      push(idx, 2'b10);
      push(idx, 2'b01);
      g = gap + (jit ? int'(l & 8'h03) : 0);
      if (jit) l = ref_next(l);
      repeat (g) push(idx, 2'b00);
      len += 2 + g;
    end
  endtask

  task automatic cmp(input int idx);
    logic [1:0] e;
    logic [1:0] got;
    int sz;
    got = {req_w[idx], ack_w[idx]};
    case (idx)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("q_empty%0d", idx), 8'd0, 8'd1);
      return;
    end
    case (idx)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk($sformatf("seq%0d", idx), {6'd0, got}, {6'd0, e});
    chk($sformatf("ovl%0d", idx), {7'd0, got[1] & got[0]}, 8'd0);
    chk($sformatf("ack_past%0d", idx), {7'd0, got[0] & ~prv[idx]}, 8'd0);
    if (idx == 0 && got == 2'b01 && prv[0] && $time < 100) hits++;
    prv[idx] = got[1];
  endtask

  initial begin
    bit found;
    rst_n = 3'b000;
    prv   = 3'b000;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_req%0d", i), {7'd0, req_w[i]}, 8'd0);
      chk($sformatf("rst_ack%0d", i), {7'd0, ack_w[i]}, 8'd0);
    end
    #8;
    rst_n = 3'b111;
    fill(0, 1, 2, 1'b0, 48);
    fill(1, 0, 0, 1'b0, 48);
    fill(2, 1, 2, 1'b1, 48);
    repeat (40) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) cmp(i);
    end
    chk("cover_100", {7'd0, hits > 0}, 8'd1);

    // reset asserted while REQ is high on the default instance
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(posedge clk);
      #1;
      if (req_w[0]) found = 1'b1;
    end
    chk("req_wait", {7'd0, found}, 8'd1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_req", {7'd0, req_w[0]}, 8'd0);
    chk("mid_rst_ack", {7'd0, ack_w[0]}, 8'd0);
    @(posedge clk);
    #1;
    chk("held_rst_ack", {7'd0, ack_w[0]}, 8'd0);
    chk("held_rst_req", {7'd0, req_w[0]}, 8'd0);
    rst_n[0] = 1'b1;
    prv[0] = 1'b0;
    fill(0, 1, 2, 1'b0, 20);
    repeat (16) begin
      @(posedge clk);
      #1;
      cmp(0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
